// File: rtl/flex_counter_pkg.sv
// Shared types and constants for the flex counter family.
// Build option: FLEX_RCNT_EN adds a saturating wrap-event counter.
package flex_counter_pkg;

  typedef enum logic [1:0] {
    CM_WRAP    = 2'd0,
    CM_SAT     = 2'd1,
    CM_ONESHOT = 2'd2,
    CM_RSVD    = 2'd3
  } cnt_mode_t;

  localparam cnt_mode_t CM_DEFAULT   = CM_WRAP;
  localparam int        NUM_BITS_MIN = 2;

endpackage

// File: rtl/flex_counter_v2_if.sv
// Control/status bundle between a flex_counter_v2 and its driver.
// rollover_cnt only exists when FLEX_RCNT_EN is defined.
interface flex_counter_v2_if #(
  parameter int NUM_BITS = 4
`ifdef FLEX_RCNT_EN
  , parameter int RCNT_BITS = 8
`endif
);
  import flex_counter_pkg::*;

  logic                clear;
  logic                load;
  logic [NUM_BITS-1:0] load_val;
  logic                count_enable;
  logic                count_up;
  cnt_mode_t           mode;
  logic [NUM_BITS-1:0] rollover_val;
  logic [NUM_BITS-1:0] count_out;
  logic                rollover_flag;
  logic                done;
`ifdef FLEX_RCNT_EN
  logic [RCNT_BITS-1:0] rollover_cnt;
`endif

  modport master (
    output clear, load, load_val, count_enable, count_up, mode, rollover_val,
    input  count_out, rollover_flag, done
`ifdef FLEX_RCNT_EN
    , input rollover_cnt
`endif
  );

  modport slave (
    input  clear, load, load_val, count_enable, count_up, mode, rollover_val,
    output count_out, rollover_flag, done
`ifdef FLEX_RCNT_EN
    , output rollover_cnt
`endif
  );

endinterface

// File: rtl/flex_next_count.sv
// Step function of the flex counter: the value one enabled step would produce.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the step is taken.
module flex_next_count
  import flex_counter_pkg::*;
#(
  parameter int NUM_BITS = 4
) (
  input  logic [NUM_BITS-1:0] count,
  input  logic [NUM_BITS-1:0] rollover_val,
  input  logic                count_up,
  input  cnt_mode_t           mode,
  output logic [NUM_BITS-1:0] next_count,
  output logic                wrap_event,
  output logic                hit_terminal
);

  localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

  logic [NUM_BITS-1:0] w_term;
  logic                w_hold_at_term;

  always_comb begin
    next_count     = count;
    wrap_event     = 1'b0;
    hit_terminal   = 1'b0;
    w_term         = count_up ? rollover_val : ONE;
    w_hold_at_term = (mode == CM_SAT) || (mode == CM_ONESHOT);

    // A zero rollover value freezes the count entirely.
    if (rollover_val != '0) begin
      if (count_up) begin
        if (count < rollover_val) begin
          next_count = count + ONE;
        end else if ((count == rollover_val) && w_hold_at_term) begin
          next_count = count;
        end else begin
          next_count = ONE;
          wrap_event = !w_hold_at_term;
        end
      end else begin
        if (count > rollover_val) begin
          next_count = rollover_val;
        end else if ((count == ONE) && w_hold_at_term) begin
          next_count = count;
        end else if (count <= ONE) begin
          next_count = rollover_val;
          wrap_event = !w_hold_at_term;
        end else begin
          next_count = count - ONE;
        end
      end
      hit_terminal = (next_count == w_term);
    end
  end

endmodule

// File: rtl/flex_counter_v2.sv
// Up/down counter with load, wrap/saturate/one-shot modes; FLEX_RCNT_EN adds rollover_cnt.
// Latency: every input reaches the registered outputs on the next rising edge.
// Backpressure: none; count_enable is ignored while done is set.
module flex_counter_v2
  import flex_counter_pkg::*;
#(
  parameter int NUM_BITS = 4
`ifdef FLEX_RCNT_EN
  , parameter int RCNT_BITS = 8
`endif
) (
  input logic               clk,
  input logic               n_rst,
  flex_counter_v2_if.slave  bus
);

  localparam logic [NUM_BITS-1:0] ONE = NUM_BITS'(1);

  logic [NUM_BITS-1:0] r_count;
  logic                r_flag;
  logic                r_done;

  logic [NUM_BITS-1:0] w_step_count;
  logic                w_wrap;
  logic                w_hit;
  logic                w_step;
  logic [NUM_BITS-1:0] w_count_d;
  logic                w_done_d;
  logic                w_flag_d;
  logic                w_wrap_taken;
  logic [NUM_BITS-1:0] w_term;

  flex_next_count #(
    .NUM_BITS (NUM_BITS)
  ) u_next (
    .count        (r_count),
    .rollover_val (bus.rollover_val),
    .count_up     (bus.count_up),
    .mode         (bus.mode),
    .next_count   (w_step_count),
    .wrap_event   (w_wrap),
    .hit_terminal (w_hit)
  );

  // A completed one-shot parks the counter until clear or load.
  assign w_step = bus.count_enable && !r_done;

  always_comb begin
    w_count_d    = r_count;
    w_done_d     = r_done;
    w_wrap_taken = 1'b0;
    if (bus.clear) begin
      w_count_d = '0;
      w_done_d  = 1'b0;
    end else if (bus.load) begin
      w_count_d = bus.load_val;
      w_done_d  = 1'b0;
    end else if (w_step) begin
      w_count_d    = w_step_count;
      w_wrap_taken = w_wrap;
      if ((bus.mode == CM_ONESHOT) && w_hit) begin
        w_done_d = 1'b1;
      end
    end
  end

  assign w_term   = bus.count_up ? bus.rollover_val : ONE;
  assign w_flag_d = (bus.rollover_val != '0) && (w_count_d == w_term);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_count <= '0;
      r_flag  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_d;
      r_flag  <= w_flag_d;
      r_done  <= w_done_d;
    end
  end

  assign bus.count_out     = r_count;
  assign bus.rollover_flag = r_flag;
  assign bus.done          = r_done;

`ifdef FLEX_RCNT_EN
  logic [RCNT_BITS-1:0] r_rcnt;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_rcnt <= '0;
    end else if (bus.clear) begin
      r_rcnt <= '0;
    end else if (w_wrap_taken && (r_rcnt != '1)) begin
      r_rcnt <= r_rcnt + RCNT_BITS'(1);
    end
  end

  assign bus.rollover_cnt = r_rcnt;
`else
  logic w_unused_wrap;
  assign w_unused_wrap = w_wrap_taken;
`endif

endmodule

// File: tb/tb_flex_counter_v2.sv
// Directed and randomized bench for flex_counter_v2 against a behavioural model.
module tb_flex_counter_v2;
  import flex_counter_pkg::*;

  localparam int NB       = 4;
  localparam int RCNT_MAX = 255;
`ifdef FLEX_RCNT_EN
  localparam int RCB = 8;
`endif

  logic clk;
  logic n_rst;

  int checks   = 0;
  int failures = 0;

  int m_cnt;
  int m_rcnt;
  bit m_flag;
  bit m_done;

  bit t_clear, t_load, t_en, t_up;
  int t_lv, t_mode, t_rv;

  flex_counter_v2_if #(
    .NUM_BITS (NB)
`ifdef FLEX_RCNT_EN
    , .RCNT_BITS (RCB)
`endif
  ) bus ();

  flex_counter_v2 #(
    .NUM_BITS (NB)
`ifdef FLEX_RCNT_EN
    , .RCNT_BITS (RCB)
`endif
  ) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt  = 0;
    m_rcnt = 0;
    m_flag = 1'b0;
    m_done = 1'b0;
  endtask

  task automatic model_edge();
    int term;
    bit holds;
    bit wrapped;
    term    = t_up ? t_rv : 1;
    holds   = (t_mode == 1) || (t_mode == 2);
    wrapped = 1'b0;
    if (t_clear) begin
      m_cnt  = 0;
      m_done = 1'b0;
      m_rcnt = 0;
    end else if (t_load) begin
      m_cnt  = t_lv;
      m_done = 1'b0;
    end else if (t_en && !m_done && t_rv != 0) begin
      if (t_up) begin
        if (m_cnt < t_rv) m_cnt = m_cnt + 1;
        else if (!(holds && m_cnt == t_rv)) begin
          m_cnt   = 1;
          wrapped = !holds;
        end
      end else begin
        if (m_cnt > t_rv) m_cnt = t_rv;
        else if (m_cnt >= 2) m_cnt = m_cnt - 1;
        else if (!(holds && m_cnt == 1)) begin
          m_cnt   = t_rv;
          wrapped = !holds;
        end
      end
      if (t_mode == 2 && m_cnt == term) m_done = 1'b1;
      if (wrapped && m_rcnt < RCNT_MAX) m_rcnt = m_rcnt + 1;
    end
    m_flag = (t_rv != 0) && (m_cnt == term);
  endtask

  task automatic cycle(input bit c, input bit l, input int lv, input bit en,
                       input bit up, input int md, input int rv);
    t_clear = c;  t_load = l;  t_lv = lv;  t_en = en;
    t_up = up;    t_mode = md; t_rv = rv;
    bus.clear        = c;
    bus.load         = l;
    bus.load_val     = NB'(lv);
    bus.count_enable = en;
    bus.count_up     = up;
    bus.mode         = cnt_mode_t'(md);
    bus.rollover_val = NB'(rv);
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    bus.clear = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    bus.count_enable = 1'b0; bus.count_up = 1'b1;
    bus.mode = CM_DEFAULT; bus.rollover_val = '0;
    #2;
    checks++; if (bus.count_out !== '0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count_out); end
    checks++; if (bus.rollover_flag !== 1'b0) begin failures++; $display("FAIL reset_flag got=%0b exp=0", bus.rollover_flag); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", bus.done); end
`ifdef FLEX_RCNT_EN
    checks++; if (bus.rollover_cnt !== '0) begin failures++; $display("FAIL reset_rcnt got=%0d exp=0", bus.rollover_cnt); end
`endif
    @(negedge clk);
    n_rst = 1'b1;
    model_reset();
  endtask

  task automatic test_wrap_up();
    int exp [12];
    exp = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5, 1, 2};
    for (int i = 0; i < 12; i++) begin
      cycle(0, 0, 0, 1, 1, 0, 5);
      checks++; if (bus.count_out !== NB'(exp[i])) begin failures++; $display("FAIL wrap_up_count[%0d] got=%0d exp=%0d", i, bus.count_out, exp[i]); end
      checks++; if (bus.rollover_flag !== (exp[i] == 5)) begin failures++; $display("FAIL wrap_up_flag[%0d] got=%0b exp=%0b", i, bus.rollover_flag, exp[i] == 5); end
    end
`ifdef FLEX_RCNT_EN
    checks++; if (bus.rollover_cnt !== 8'd2) begin failures++; $display("FAIL wrap_up_rcnt got=%0d exp=2", bus.rollover_cnt); end
`endif
  endtask

  task automatic test_wrap_down();
    int exp [6];
    exp = '{3, 2, 1, 3, 2, 1};
    cycle(1, 0, 0, 0, 0, 0, 3);
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 1, 0, 0, 3);
      checks++; if (bus.count_out !== NB'(exp[i])) begin failures++; $display("FAIL wrap_down_count[%0d] got=%0d exp=%0d", i, bus.count_out, exp[i]); end
      checks++; if (bus.rollover_flag !== (exp[i] == 1)) begin failures++; $display("FAIL wrap_down_flag[%0d] got=%0b exp=%0b", i, bus.rollover_flag, exp[i] == 1); end
    end
  endtask

  task automatic test_sat();
    int exp [8];
    exp = '{1, 2, 3, 4, 4, 4, 4, 4};
    cycle(1, 0, 0, 0, 1, 1, 4);
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 1, 1, 1, 4);
      checks++; if (bus.count_out !== NB'(exp[i])) begin failures++; $display("FAIL sat_count[%0d] got=%0d exp=%0d", i, bus.count_out, exp[i]); end
      checks++; if (bus.rollover_flag !== (exp[i] == 4)) begin failures++; $display("FAIL sat_flag[%0d] got=%0b exp=%0b", i, bus.rollover_flag, exp[i] == 4); end
      checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL sat_done[%0d] got=%0b exp=0", i, bus.done); end
    end
  endtask

  task automatic test_oneshot();
    int exp_c [5];
    bit exp_d [5];
    exp_c = '{1, 2, 2, 2, 2};
    exp_d = '{0, 1, 1, 1, 1};
    cycle(1, 0, 0, 0, 1, 2, 2);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 1, 1, 2, 2);
      checks++; if (bus.count_out !== NB'(exp_c[i])) begin failures++; $display("FAIL oneshot_count[%0d] got=%0d exp=%0d", i, bus.count_out, exp_c[i]); end
      checks++; if (bus.done !== exp_d[i]) begin failures++; $display("FAIL oneshot_done[%0d] got=%0b exp=%0b", i, bus.done, exp_d[i]); end
    end
    cycle(0, 1, 0, 1, 1, 2, 2);
    checks++; if (bus.count_out !== '0) begin failures++; $display("FAIL oneshot_load_count got=%0d exp=0", bus.count_out); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL oneshot_load_done got=%0b exp=0", bus.done); end
  endtask

  task automatic test_priority();
`ifdef FLEX_RCNT_EN
    int rc_before;
`endif
    cycle(0, 1, 7, 0, 1, 0, 15);
    checks++; if (bus.count_out !== 4'd7) begin failures++; $display("FAIL prio_load7 got=%0d exp=7", bus.count_out); end
    cycle(1, 1, 9, 1, 1, 0, 15);
    checks++; if (bus.count_out !== 4'd0) begin failures++; $display("FAIL prio_clear got=%0d exp=0", bus.count_out); end
    cycle(0, 1, 9, 1, 1, 0, 15);
    checks++; if (bus.count_out !== 4'd9) begin failures++; $display("FAIL prio_load_over_en got=%0d exp=9", bus.count_out); end
`ifdef FLEX_RCNT_EN
    rc_before = int'(bus.rollover_cnt);
`endif
    cycle(0, 0, 0, 1, 1, 0, 4);
    checks++; if (bus.count_out !== 4'd1) begin failures++; $display("FAIL prio_lower_rv got=%0d exp=1", bus.count_out); end
    checks++; if (bus.rollover_flag !== 1'b0) begin failures++; $display("FAIL prio_lower_rv_flag got=%0b exp=0", bus.rollover_flag); end
`ifdef FLEX_RCNT_EN
    checks++; if (int'(bus.rollover_cnt) !== rc_before + 1) begin failures++; $display("FAIL prio_wrap_event got=%0d exp=%0d", bus.rollover_cnt, rc_before + 1); end
`endif
  endtask

  task automatic test_rv_zero();
    cycle(0, 1, 3, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 1, i[0], 0, 0);
      checks++; if (bus.count_out !== 4'd3) begin failures++; $display("FAIL rv0_hold[%0d] got=%0d exp=3", i, bus.count_out); end
      checks++; if (bus.rollover_flag !== 1'b0) begin failures++; $display("FAIL rv0_flag[%0d] got=%0b exp=0", i, bus.rollover_flag); end
    end
    cycle(0, 1, 1, 0, 0, 0, 0);
    checks++; if (bus.rollover_flag !== 1'b0) begin failures++; $display("FAIL rv0_flag_at_one got=%0b exp=0", bus.rollover_flag); end
  endtask

  task automatic test_async_reset();
    cycle(1, 0, 0, 0, 1, 0, 10);
    for (int i = 0; i < 6; i++) cycle(0, 0, 0, 1, 1, 0, 10);
    checks++; if (bus.count_out !== 4'd6) begin failures++; $display("FAIL arst_precount got=%0d exp=6", bus.count_out); end
    #2;
    n_rst = 1'b0;
    #1;
    model_reset();
    checks++; if (bus.count_out !== '0) begin failures++; $display("FAIL arst_count got=%0d exp=0", bus.count_out); end
    checks++; if (bus.rollover_flag !== 1'b0) begin failures++; $display("FAIL arst_flag got=%0b exp=0", bus.rollover_flag); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL arst_done got=%0b exp=0", bus.done); end
`ifdef FLEX_RCNT_EN
    checks++; if (bus.rollover_cnt !== '0) begin failures++; $display("FAIL arst_rcnt got=%0d exp=0", bus.rollover_cnt); end
`endif
    @(posedge clk);
    #1;
    checks++; if (bus.count_out !== '0) begin failures++; $display("FAIL arst_held got=%0d exp=0", bus.count_out); end
    #2;
    n_rst = 1'b1;
    cycle(0, 0, 0, 1, 1, 0, 10);
    checks++; if (bus.count_out !== 4'd1) begin failures++; $display("FAIL arst_resume got=%0d exp=1", bus.count_out); end
  endtask

  task automatic test_random();
    bit up;
    int md, rv;
    up = 1'b1; md = 0; rv = 6;
    cycle(1, 0, 0, 0, up, md, rv);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) rv = $urandom_range(0, 15);
      if ($urandom_range(0, 9) == 0) md = $urandom_range(0, 3);
      if ($urandom_range(0, 9) == 0) up = ~up;
      cycle($urandom_range(0, 24) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 15), $urandom_range(0, 3) != 0, up, md, rv);
      checks++; if (bus.count_out !== NB'(m_cnt)) begin failures++; $display("FAIL rand_count[%0d] got=%0d exp=%0d", i, bus.count_out, m_cnt); end
      checks++; if (bus.rollover_flag !== m_flag) begin failures++; $display("FAIL rand_flag[%0d] got=%0b exp=%0b", i, bus.rollover_flag, m_flag); end
      checks++; if (bus.done !== m_done) begin failures++; $display("FAIL rand_done[%0d] got=%0b exp=%0b", i, bus.done, m_done); end
`ifdef FLEX_RCNT_EN
      checks++; if (bus.rollover_cnt !== RCB'(m_rcnt)) begin failures++; $display("FAIL rand_rcnt[%0d] got=%0d exp=%0d", i, bus.rollover_cnt, m_rcnt); end
`endif
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_wrap_up();
    test_wrap_down();
    test_sat();
    test_oneshot();
    test_priority();
    test_rv_zero();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
